// File: rtl/axi_lite_regfile_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile_slave
//
// AXI4-Lite responder that serves a bank of NUM_REGS word registers located
// at BASE_ADDR. The write address and write data channels are accepted
// independently, in either order or together, and each write produces exactly
// one B response. Reads are served one at a time with a registered R response.
// The register contents are exported flat on reg_q for hardware observers.
//
// Ports:
//   aclk, areset_n          clock, synchronous active-low reset
//   awaddr/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready write data channel (byte strobes)
//   bresp/bvalid/bready     write response channel
//   araddr/arvalid/arready  read address channel
//   rdata/rresp/rvalid/rready read data channel
//   reg_q                   register k occupies bits [32k+31:32k]
//
// Accesses outside [BASE_ADDR, BASE_ADDR + 4*NUM_REGS) answer SLVERR,
// write nothing and read as zero. Address bits [1:0] are ignored.
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module axi_lite_regfile_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           aclk,
    input  logic                           areset_n,

    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,

    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,

    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,

    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,

    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int                    STRB_W = DATA_WIDTH / 8;
    localparam int                    IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(4 * NUM_REGS);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_AW,
        W_WAIT_W,
        W_RESP
    } wState_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rState_t;

    // The extra top bit of the difference is the borrow, which flags
    // addresses below BASE_ADDR without a separate constant comparison.
    function automatic logic isHit(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] < WINDOW);
    endfunction

    function automatic logic [IDX_W-1:0] regIndex(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    wState_t                 wState_q;
    rState_t                 rState_q;
    logic                    awReady_q;
    logic                    wReady_q;
    logic                    bValid_q;
    logic [1:0]              bResp_q;
    logic [ADDR_WIDTH-1:0]   awAddr_q;
    logic [DATA_WIDTH-1:0]   wData_q;
    logic [STRB_W-1:0]       wStrb_q;
    logic                    arReady_q;
    logic                    rValid_q;
    logic [1:0]              rResp_q;
    logic [DATA_WIDTH-1:0]   rData_q;
    logic [DATA_WIDTH-1:0]   regFile_q [NUM_REGS];

    logic                    awHs;
    logic                    wHs;
    logic                    arHs;
    logic                    commitEn_d;
    logic [ADDR_WIDTH-1:0]   commitAddr_d;
    logic [DATA_WIDTH-1:0]   commitData_d;
    logic [STRB_W-1:0]       commitStrb_d;
    logic                    commitHit;
    logic [IDX_W-1:0]        commitIdx;

    assign awHs = awvalid && awReady_q;
    assign wHs  = wvalid  && wReady_q;
    assign arHs = arvalid && arReady_q;

    // A write commits on the edge that completes the later of AW and W.
    // Whichever half arrived earlier comes from its holding register.
    always_comb begin
        commitEn_d   = 1'b0;
        commitAddr_d = awaddr;
        commitData_d = wdata;
        commitStrb_d = wstrb;
        case (wState_q)
            W_IDLE:    commitEn_d = awHs && wHs;
            W_WAIT_W: begin
                commitEn_d   = wHs;
                commitAddr_d = awAddr_q;
            end
            W_WAIT_AW: begin
                commitEn_d   = awHs;
                commitData_d = wData_q;
                commitStrb_d = wStrb_q;
            end
            default:   commitEn_d = 1'b0;
        endcase
    end

    assign commitHit = isHit(commitAddr_d);
    assign commitIdx = regIndex(commitAddr_d);

    // Write FSM. Readies are 0 straight out of reset and come up on the first
    // edge in W_IDLE; both stay low while a response is outstanding, which
    // limits the write rate to one per two cycles.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wState_q  <= W_IDLE;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bResp_q   <= RESP_OKAY;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
        end else begin
            case (wState_q)
                W_IDLE: begin
                    awReady_q <= 1'b1;
                    wReady_q  <= 1'b1;
                    if (commitEn_d) begin
                        awReady_q <= 1'b0;
                        wReady_q  <= 1'b0;
                        bValid_q  <= 1'b1;
                        bResp_q   <= commitHit ? RESP_OKAY : RESP_SLVERR;
                        wState_q  <= W_RESP;
                    end else if (awHs) begin
                        awAddr_q  <= awaddr;
                        awReady_q <= 1'b0;
                        wState_q  <= W_WAIT_W;
                    end else if (wHs) begin
                        wData_q  <= wdata;
                        wStrb_q  <= wstrb;
                        wReady_q <= 1'b0;
                        wState_q <= W_WAIT_AW;
                    end
                end
                W_WAIT_W, W_WAIT_AW: begin
                    if (commitEn_d) begin
                        awReady_q <= 1'b0;
                        wReady_q  <= 1'b0;
                        bValid_q  <= 1'b1;
                        bResp_q   <= commitHit ? RESP_OKAY : RESP_SLVERR;
                        wState_q  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bValid_q  <= 1'b0;
                        awReady_q <= 1'b1;
                        wReady_q  <= 1'b1;
                        wState_q  <= W_IDLE;
                    end
                end
                default: wState_q <= W_IDLE;
            endcase
        end
    end

    // Register bank: byte lanes are written only where the strobe is set,
    // and only for addresses inside the window.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regFile_q[k] <= '0;
            end
        end else if (commitEn_d && commitHit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (commitStrb_d[b]) begin
                    regFile_q[commitIdx][8*b +: 8] <= commitData_d[8*b +: 8];
                end
            end
        end
    end

    // Read FSM. The bank is sampled before any same-edge write lands, so a
    // read racing a write to the same register returns the old value.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rState_q  <= R_IDLE;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
            rResp_q   <= RESP_OKAY;
            rData_q   <= '0;
        end else begin
            case (rState_q)
                R_IDLE: begin
                    arReady_q <= 1'b1;
                    if (arHs) begin
                        arReady_q <= 1'b0;
                        rValid_q  <= 1'b1;
                        if (isHit(araddr)) begin
                            rData_q <= regFile_q[regIndex(araddr)];
                            rResp_q <= RESP_OKAY;
                        end else begin
                            rData_q <= '0;
                            rResp_q <= RESP_SLVERR;
                        end
                        rState_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rValid_q  <= 1'b0;
                        arReady_q <= 1'b1;
                        rState_q  <= R_IDLE;
                    end
                end
                default: rState_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awReady_q;
    assign wready  = wReady_q;
    assign bvalid  = bValid_q;
    assign bresp   = bResp_q;
    assign arready = arReady_q;
    assign rvalid  = rValid_q;
    assign rresp   = rResp_q;
    assign rdata   = rData_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : gRegOut
        assign reg_q[DATA_WIDTH*k +: DATA_WIDTH] = regFile_q[k];
    end

endmodule
